// File: rtl/zoom_pkg.sv
// Shared mode codes, FSM state encoding and per-mode geometry for the zoom engine.
// Geometry helper gives reads-per-pixel (k) and destination dimensions for a mode.
package zoom_pkg;

  localparam logic [1:0] MODE_NN   = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_AVG  = 2'b10;
  localparam logic [1:0] MODE_COPY = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  typedef struct packed {
    logic [2:0] k;
    logic [9:0] w;
    logic [9:0] h;
  } dims_t;

  function automatic dims_t mode_dims(input logic [1:0] mode, input int src_w, input int src_h);
    dims_t d;
    d.k = 3'd1;
    d.w = 10'(src_w);
    d.h = 10'(src_h);
    case (mode)
      MODE_NN: begin
        d.w = 10'(2 * src_w);
        d.h = 10'(2 * src_h);
      end
      MODE_DEC: begin
        d.w = 10'(src_w / 2);
        d.h = 10'(src_h / 2);
      end
      MODE_AVG: begin
        d.k = 3'd4;
        d.w = 10'(src_w / 2);
        d.h = 10'(src_h / 2);
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/zoom_if.sv
// Control handshake plus source-read and destination-write buses of the zoom engine.
// master = engine side, slave = controller / memories side.
interface zoom_if #(
  parameter int PIX_W  = 8,
  parameter int SRC_AW = 15,
  parameter int DST_AW = 17
);
  logic              start;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic [9:0]        dst_width;
  logic [SRC_AW-1:0] src_addr;
  logic [PIX_W-1:0]  src_data;
  logic [DST_AW-1:0] dst_addr;
  logic [PIX_W-1:0]  dst_data;
  logic              dst_wren;

  modport master (
    input  start, mode, src_data,
    output busy, done, dst_width, src_addr, dst_addr, dst_data, dst_wren
  );

  modport slave (
    output start, mode, src_data,
    input  busy, done, dst_width, src_addr, dst_addr, dst_data, dst_wren
  );
endinterface

// File: rtl/zoom_addr_gen.sv
// Combinational address mapping: destination (dx,dy) plus read index to source address,
// and (dx,dy) to row-major destination address. Zero latency, no flow control.
module zoom_addr_gen
  import zoom_pkg::*;
#(
  parameter int SRC_W  = 160,
  parameter int SRC_AW = 15,
  parameter int DST_AW = 17
) (
  input  logic [9:0]        dx,
  input  logic [9:0]        dy,
  input  logic [1:0]        mode,
  input  logic [1:0]        rd_idx,
  input  logic [9:0]        dst_width,
  output logic [SRC_AW-1:0] src_addr,
  output logic [DST_AW-1:0] dst_addr
);

  logic [9:0] sx;
  logic [9:0] sy;

  always_comb begin
    sx = dx;
    sy = dy;
    case (mode)
      MODE_NN: begin
        sx = {1'b0, dx[9:1]};
        sy = {1'b0, dy[9:1]};
      end
      MODE_DEC: begin
        sx = {dx[8:0], 1'b0};
        sy = {dy[8:0], 1'b0};
      end
      // 2x2 block: rd_idx bit 0 selects column, bit 1 selects row
      MODE_AVG: begin
        sx = {dx[8:0], rd_idx[0]};
        sy = {dy[8:0], rd_idx[1]};
      end
      default: ;
    endcase
    src_addr = SRC_AW'(sy) * SRC_AW'(SRC_W) + SRC_AW'(sx);
    dst_addr = DST_AW'(dy) * DST_AW'(dst_width) + DST_AW'(dx);
  end

endmodule

// File: rtl/zoom_engine.sv
// Rescaling frame engine: k reads, RD_LAT wait, one write per destination pixel
// (k+RD_LAT+1 cycles/pixel, reads not overlapped); START accepted only in IDLE.
module zoom_engine
  import zoom_pkg::*;
#(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int PIX_W  = 8,
  parameter int SRC_AW = 15,
  parameter int DST_AW = 17,
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   reset,
  zoom_if.master bus
);

  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  if ((SRC_W % 2) != 0 || (SRC_H % 2) != 0) begin : g_bad_dims
    $error("zoom_engine: SRC_W and SRC_H must be even");
  end
  if ((longint'(1) << SRC_AW) < longint'(SRC_W) * longint'(SRC_H)) begin : g_bad_src_aw
    $error("zoom_engine: SRC_AW too small");
  end
  if ((longint'(1) << DST_AW) < 4 * longint'(SRC_W) * longint'(SRC_H)) begin : g_bad_dst_aw
    $error("zoom_engine: DST_AW too small");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("zoom_engine: RD_LAT must be >= 1");
  end

  logic [2:0]        state;
  logic [1:0]        mode_q;
  logic [9:0]        dst_w;
  logic [9:0]        dst_h;
  logic [2:0]        k_q;
  logic [9:0]        dx;
  logic [9:0]        dy;
  logic [1:0]        rd_idx;
  logic [WCW-1:0]    wait_cnt;
  logic [RD_LAT-1:0] vld;
  logic [PIX_W+1:0]  acc;
  logic [PIX_W+1:0]  acc_sum;
  logic [PIX_W-1:0]  result;
  logic [SRC_AW-1:0] gen_src;
  logic [SRC_AW-1:0] src_q;
  logic [DST_AW-1:0] gen_dst;
  logic [DST_AW-1:0] dst_addr_q;
  logic [PIX_W-1:0]  dst_data_q;
  logic              wren_q;
  logic              issue;
  logic              last_rd;
  logic              last_wait;
  dims_t             dims;

  zoom_addr_gen #(.SRC_W(SRC_W), .SRC_AW(SRC_AW), .DST_AW(DST_AW)) u_addr_gen (
    .dx        (dx),
    .dy        (dy),
    .mode      (mode_q),
    .rd_idx    (rd_idx),
    .dst_width (dst_w),
    .src_addr  (gen_src),
    .dst_addr  (gen_dst)
  );

  assign dims      = mode_dims(bus.mode, SRC_W, SRC_H);
  assign issue     = (state == ST_ISSUE);
  assign last_rd   = ({1'b0, rd_idx} == (k_q - 3'd1));
  assign last_wait = (state == ST_WAIT) && (wait_cnt == WCW'(RD_LAT - 1));
  // Sum includes the sample arriving this cycle so WRITE sees the complete block
  assign acc_sum   = acc + (vld[RD_LAT-1] ? {2'b00, bus.src_data} : '0);
  assign result    = (mode_q == MODE_AVG) ? acc_sum[PIX_W+1:2] : acc_sum[PIX_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      dst_w      <= '0;
      dst_h      <= '0;
      k_q        <= '0;
      dx         <= '0;
      dy         <= '0;
      rd_idx     <= '0;
      wait_cnt   <= '0;
      vld        <= '0;
      acc        <= '0;
      src_q      <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      wren_q     <= 1'b0;
    end else begin
      vld    <= (vld << 1) | RD_LAT'(issue);
      acc    <= acc_sum;
      wren_q <= 1'b0;
      if (issue) src_q <= gen_src;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            dst_w  <= dims.w;
            dst_h  <= dims.h;
            k_q    <= dims.k;
            dx     <= '0;
            dy     <= '0;
            rd_idx <= '0;
            acc    <= '0;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rd_idx <= rd_idx + 2'd1;
          if (last_rd) begin
            rd_idx   <= '0;
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (last_wait) begin
            wren_q     <= 1'b1;
            dst_addr_q <= gen_dst;
            dst_data_q <= result;
            state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          acc <= '0;
          if (dx == dst_w - 10'd1) begin
            dx <= '0;
            if (dy == dst_h - 10'd1) begin
              state <= ST_FIN;
            end else begin
              dy    <= dy + 10'd1;
              state <= ST_ISSUE;
            end
          end else begin
            dx    <= dx + 10'd1;
            state <= ST_ISSUE;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_WRITE);
  assign bus.done      = (state == ST_FIN);
  assign bus.dst_width = dst_w;
  assign bus.src_addr  = issue ? gen_src : src_q;
  assign bus.dst_addr  = dst_addr_q;
  assign bus.dst_data  = dst_data_q;
  assign bus.dst_wren  = wren_q;

endmodule
